// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store sequencer and its lane aligner.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RD   = 2'd1;
   localparam state_t ST_WR   = 2'd2;
   localparam state_t ST_RESP = 2'd3;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: sub-word load extract/extend and sub-word store merge.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [31:0] byte_lane;
   logic [31:0] half_lane;
   logic [31:0] byte_mask;
   logic [31:0] half_mask;

   always_comb begin
      byte_sh   = {addr_lo, 3'b000};
      half_sh   = {addr_lo[1], 4'b0000};
      byte_lane = word >> byte_sh;
      half_lane = word >> half_sh;
      byte_mask = 32'h0000_00FF << byte_sh;
      half_mask = 32'h0000_FFFF << half_sh;

      case (size)
         SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_lane[7:0]}
                                          : {{24{byte_lane[7]}}, byte_lane[7:0]};
         SZ_HALF: load_data = is_unsigned ? {16'h0, half_lane[15:0]}
                                          : {{16{half_lane[15]}}, half_lane[15:0]};
         default: load_data = word;
      endcase

      case (size)
         SZ_BYTE: store_data = (word & ~byte_mask) | ({24'h0, wdata[7:0]} << byte_sh);
         SZ_HALF: store_data = (word & ~half_mask) | ({16'h0, wdata[15:0]} << half_sh);
         default: store_data = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the word-addressed DataMemory port: alignment check,
// read-modify-write for sub-word stores, extend on sub-word loads.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
)(
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic                  ReqStore,
   input  logic [1:0]            ReqSize,
   input  logic                  ReqUnsigned,
   input  logic [ADDR_WIDTH-1:0] ReqAddr,
   input  logic [DATA_WIDTH-1:0] ReqWData,
   output logic                  RespValid,
   output logic [DATA_WIDTH-1:0] RespData,
   output logic                  RespErr,
   output logic [ADDR_WIDTH-1:0] MemAddress,
   output logic [DATA_WIDTH-1:0] MemWriteData,
   output logic                  MemWrite,
   output logic                  MemRead,
   input  logic [DATA_WIDTH-1:0] MemReadData
);

   state_t                  state;
   logic                    r_store;
   logic [1:0]              r_size;
   logic                    r_unsigned;
   logic                    r_err;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH-1:0]   r_word;

   logic [DATA_WIDTH-1:0]   load_data;
   logic [DATA_WIDTH-1:0]   store_data;
   logic                    req_bad;

   assign req_bad = is_misaligned(ReqSize, ReqAddr[1:0]);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= ST_IDLE;
         r_store    <= 1'b0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_word     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ReqValid) begin
                  r_store    <= ReqStore;
                  r_size     <= ReqSize;
                  r_unsigned <= ReqUnsigned;
                  r_err      <= req_bad;
                  r_addr     <= ReqAddr;
                  r_wdata    <= ReqWData;
                  if (req_bad)
                     state <= ST_RESP;
                  else if (ReqStore && ReqSize == SZ_WORD)
                     state <= ST_WR;
                  else
                     state <= ST_RD;
               end
            end
            ST_RD: begin
               r_word <= MemReadData;
               state  <= r_store ? ST_WR : ST_RESP;
            end
            ST_WR:   state <= ST_RESP;
            default: state <= ST_IDLE;
         endcase
      end
   end

   mem_lane_align u_align (
      .word        (r_word),
      .wdata       (r_wdata),
      .addr_lo     (r_addr[1:0]),
      .size        (r_size),
      .is_unsigned (r_unsigned),
      .load_data   (load_data),
      .store_data  (store_data)
   );

   // Memory strobes are pure state decodes so an async reset drops MemWrite at once.
   always_comb begin
      ReqReady     = (state == ST_IDLE);
      MemRead      = (state == ST_RD);
      MemWrite     = (state == ST_WR);
      MemAddress   = '0;
      MemWriteData = '0;
      RespValid    = (state == ST_RESP);
      RespErr      = 1'b0;
      RespData     = '0;
      if (state == ST_RD || state == ST_WR)
         MemAddress = {r_addr[ADDR_WIDTH-1:2], 2'b00};
      if (state == ST_WR)
         MemWriteData = store_data;
      if (state == ST_RESP) begin
         RespErr = r_err;
         if (!r_store && !r_err)
            RespData = load_data;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a small behavioural DataMemory.
module tb_mem_access_unit;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqStore;
   logic [1:0]  ReqSize;
   logic        ReqUnsigned;
   logic [31:0] ReqAddr;
   logic [31:0] ReqWData;
   logic        RespValid;
   logic [31:0] RespData;
   logic        RespErr;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] MemReadData;

   always #5 Clk = ~Clk;

   mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .ReqStore     (ReqStore),
      .ReqSize      (ReqSize),
      .ReqUnsigned  (ReqUnsigned),
      .ReqAddr      (ReqAddr),
      .ReqWData     (ReqWData),
      .RespValid    (RespValid),
      .RespData     (RespData),
      .RespErr      (RespErr),
      .MemAddress   (MemAddress),
      .MemWriteData (MemWriteData),
      .MemWrite     (MemWrite),
      .MemRead      (MemRead),
      .MemReadData  (MemReadData)
   );

   // DataMemory model: combinational read, write on rising edge; preload port for setup.
   logic [31:0] mem [0:63];
   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_data;

   assign MemReadData = mem[MemAddress[7:2]];

   always @(posedge Clk) begin
      if (pl_en)
         mem[pl_idx] <= pl_data;
      else if (MemWrite)
         mem[MemAddress[7:2]] <= MemWriteData;
   end

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        err;
      logic [31:0] maddr;
      logic [31:0] wdata;
      int          nrd;
      int          nwr;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none", nm);
   endtask

   // Monitor: pops one expectation per RespValid and tracks memory strobes in between.
   initial begin
      int   rd_n;
      int   wr_n;
      exp_t e;
      rd_n = 0;
      wr_n = 0;
      forever begin
         @(negedge Clk);
         if (!Reset_n) begin
            rd_n = 0;
            wr_n = 0;
         end else begin
            if (MemRead || MemWrite) begin
               if (q.size() == 0) fail_now("stray_mem_access");
               else chk({q[0].name, ".maddr"}, MemAddress, q[0].maddr);
            end
            if (MemRead) rd_n++;
            if (MemWrite) begin
               wr_n++;
               if (q.size() != 0) chk({q[0].name, ".wdata"}, MemWriteData, q[0].wdata);
            end
            if (RespValid) begin
               if (q.size() == 0) fail_now("stray_resp");
               else begin
                  e = q.pop_front();
                  chk({e.name, ".data"}, RespData, e.data);
                  chk({e.name, ".err"}, {31'h0, RespErr}, {31'h0, e.err});
                  chk({e.name, ".lat"}, cyc - e.acc, e.lat);
                  chk({e.name, ".nrd"}, rd_n, e.nrd);
                  chk({e.name, ".nwr"}, wr_n, e.nwr);
               end
               rd_n = 0;
               wr_n = 0;
            end
         end
      end
   end

   // Presents a request (ReqValid left high) and returns after the accepting edge.
   task automatic issue(input string nm, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] edata, input logic eerr, input logic [31:0] emaddr,
                        input logic [31:0] ewdata, input int nrd, input int nwr, input int lat,
                        output int acc);
      exp_t e;
      bit   ok;
      ReqStore    = st;
      ReqSize     = sz;
      ReqUnsigned = uns;
      ReqAddr     = addr;
      ReqWData    = wd;
      ReqValid    = 1'b1;
      ok          = 1'b0;
      acc         = 0;
      for (int i = 0; i < 20; i++) begin
         if (ReqReady) begin
            ok = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      if (!ok) begin
         fail_now({nm, ".accept_timeout"});
      end else begin
         acc     = cyc;
         e.name  = nm;   e.data  = edata; e.err = eerr;
         e.maddr = emaddr; e.wdata = ewdata;
         e.nrd   = nrd;  e.nwr   = nwr;   e.lat = lat; e.acc = acc;
         q.push_back(e);
         @(posedge Clk);
      end
   endtask

   task automatic wait_done(input string nm);
      bit ok;
      @(negedge Clk);
      ReqValid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      if (!ok) begin
         fail_now({nm, ".resp_timeout"});
         q.delete();
      end
   endtask

   initial begin
      int a1;
      int a2;
      Reset_n     = 1'b0;
      ReqValid    = 1'b0;
      ReqStore    = 1'b0;
      ReqSize     = 2'd0;
      ReqUnsigned = 1'b0;
      ReqAddr     = '0;
      ReqWData    = '0;
      pl_en       = 1'b1;
      for (int i = 0; i < 64; i++) begin
         pl_idx  = 6'(i);
         pl_data = (i == 4) ? 32'h8899AABB : (i == 9) ? 32'h11223344 : 32'h0;
         @(negedge Clk);
      end
      pl_en = 1'b0;
      @(negedge Clk);
      chk("rst.ReqReady", {31'h0, ReqReady}, 32'h1);
      chk("rst.RespValid", {31'h0, RespValid}, 32'h0);
      chk("rst.RespData", RespData, 32'h0);
      chk("rst.MemRead", {31'h0, MemRead}, 32'h0);
      chk("rst.MemWrite", {31'h0, MemWrite}, 32'h0);
      chk("rst.MemAddress", MemAddress, 32'h0);
      Reset_n = 1'b1;
      @(negedge Clk);

      // name st sz uns addr wdata | data err maddr wdata nrd nwr lat
      issue("lb_11",  0, 2'd0, 0, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 32'h10, 32'h0, 1, 0, 2, a1); wait_done("lb_11");
      issue("lbu_11", 0, 2'd0, 1, 32'h11, 32'h0, 32'h000000AA, 0, 32'h10, 32'h0, 1, 0, 2, a1); wait_done("lbu_11");
      issue("lhu_12", 0, 2'd1, 1, 32'h12, 32'h0, 32'h00008899, 0, 32'h10, 32'h0, 1, 0, 2, a1); wait_done("lhu_12");
      issue("lh_12",  0, 2'd1, 0, 32'h12, 32'h0, 32'hFFFF8899, 0, 32'h10, 32'h0, 1, 0, 2, a1); wait_done("lh_12");
      issue("lb_10",  0, 2'd0, 0, 32'h10, 32'h0, 32'hFFFFFFBB, 0, 32'h10, 32'h0, 1, 0, 2, a1); wait_done("lb_10");
      issue("sh_12",  1, 2'd1, 0, 32'h12, 32'h00001234, 32'h0, 0, 32'h10, 32'h1234AABB, 1, 1, 3, a1); wait_done("sh_12");
      issue("lw_10",  0, 2'd2, 0, 32'h10, 32'h0, 32'h1234AABB, 0, 32'h10, 32'h0, 1, 0, 2, a1); wait_done("lw_10");
      issue("sw_13",  1, 2'd2, 0, 32'h13, 32'hDEADBEEF, 32'h0, 1, 32'h0, 32'h0, 0, 0, 1, a1); wait_done("sw_13");
      chk("mem10_after_err", mem[4], 32'h1234AABB);
      issue("lh_11",  0, 2'd1, 0, 32'h11, 32'h0, 32'h0, 1, 32'h0, 32'h0, 0, 0, 1, a1); wait_done("lh_11");
      issue("rsvd",   0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 32'h0, 32'h0, 0, 0, 1, a1); wait_done("rsvd");
      issue("sb_13",  1, 2'd0, 0, 32'h13, 32'hABCDEF55, 32'h0, 0, 32'h10, 32'h5534AABB, 1, 1, 3, a1); wait_done("sb_13");
      issue("lbu_13", 0, 2'd0, 1, 32'h13, 32'h0, 32'h00000055, 0, 32'h10, 32'h0, 1, 0, 2, a1); wait_done("lbu_13");

      // Back-to-back with ReqValid held: second accept lands the cycle after RESP.
      issue("sw_20", 1, 2'd2, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 32'h20, 32'hCAFEF00D, 0, 1, 2, a1);
      @(negedge Clk);
      chk("b2b.ready_wr", {31'h0, ReqReady}, 32'h0);
      @(negedge Clk);
      chk("b2b.ready_resp", {31'h0, ReqReady}, 32'h0);
      issue("lw_20", 0, 2'd2, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 32'h20, 32'h0, 1, 0, 2, a2);
      chk("b2b.accept_gap", a2 - a1, 32'd3);
      wait_done("lw_20");

      // Reset during the WR cycle of a byte store aborts the write.
      issue("sb_abort", 1, 2'd0, 0, 32'h24, 32'h000000EE, 32'h0, 0, 32'h24, 32'h112233EE, 1, 1, 3, a1);
      #1 ReqValid = 1'b0;
      @(posedge Clk);
      #1 chk("abort.memwrite_pre", {31'h0, MemWrite}, 32'h1);
      Reset_n = 1'b0;
      q.delete();
      #1 chk("abort.memwrite_drop", {31'h0, MemWrite}, 32'h0);
      chk("abort.respvalid", {31'h0, RespValid}, 32'h0);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("abort.ready", {31'h0, ReqReady}, 32'h1);
      chk("abort.mem24", mem[9], 32'h11223344);
      issue("lw_24", 0, 2'd2, 0, 32'h24, 32'h0, 32'h11223344, 0, 32'h24, 32'h0, 1, 0, 2, a1); wait_done("lw_24");

      repeat (3) @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
